// File: rtl/rv_mmio_pkg.sv
// Shared types and default MMIO addresses for the end-of-test monitor.
// The constants are also consumed by the software test harness.
package rv_mmio_pkg;

  typedef enum logic [1:0] {
    StRun,
    StPass,
    StFail,
    StTimeout
  } mon_state_e;

  localparam logic [31:0] DefaultDoneAddr    = 32'h0000_2000;
  localparam logic [31:0] DefaultConsoleAddr = 32'h0000_2004;
  localparam logic [31:0] DefaultPassValue   = 32'hDEAD_BEEF;

endpackage

// File: rtl/rv_mmio_fifo.sv
// Synchronous FIFO with a registered head; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate counter.
module rv_mmio_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q, count;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic [AW-1:0]    rd_next_idx;
  logic             do_push, do_pop;

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (count == (AW+1)'(DEPTH));
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);
  assign head        = head_q;

  // The entry behind the head is never the write slot unless only one entry remains.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count > (AW+1)'(1)) begin
        head_d = mem_q[rd_next_idx];
      end else if (do_push) begin
        head_d = push_data;
      end
    end else if (do_push && empty) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rv_mmio_monitor.sv
// Passive end-of-test monitor: snoops data-memory stores for pass/fail/timeout
// termination, counts cycles and stores, and queues console bytes.
module rv_mmio_monitor
  import rv_mmio_pkg::*;
#(
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  DONE_ADDR      = ADDR_W'(DefaultDoneAddr),
  parameter logic [DATA_W-1:0]  PASS_VALUE     = DATA_W'(DefaultPassValue),
  parameter logic [ADDR_W-1:0]  CONSOLE_ADDR   = ADDR_W'(DefaultConsoleAddr),
  parameter int unsigned        FIFO_DEPTH     = 16,
  parameter int unsigned        CNT_W          = 32,
  parameter int unsigned        TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_din,
  output logic              done_flag,
  output logic              pass_flag,
  output logic              fail_flag,
  output logic [DATA_W-1:0] fail_code,
  output logic              timeout_flag,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  store_count,
  output logic              console_valid,
  output logic [7:0]        console_data,
  input  logic              console_ready,
  output logic              console_overflow
);

  mon_state_e        state_q;
  logic [DATA_W-1:0] fail_code_q;
  logic [CNT_W-1:0]  cycle_q, store_q;
  logic              overflow_q;
  logic              done_hit, console_hit, running, wd_expire;
  logic              fifo_full, fifo_empty;

  assign done_hit    = dmem_we && (dmem_addr == DONE_ADDR);
  assign console_hit = dmem_we && (dmem_addr == CONSOLE_ADDR);
  assign running     = (state_q == StRun);
  assign wd_expire   = (TIMEOUT_CYCLES != 0) && (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A termination store takes priority over a watchdog expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      fail_code_q <= '0;
      cycle_q     <= '0;
      store_q     <= '0;
    end else if (running) begin
      if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
      if (dmem_we && (store_q != '1)) store_q <= store_q + CNT_W'(1);
      if (done_hit) begin
        if (dmem_din == PASS_VALUE) begin
          state_q <= StPass;
        end else begin
          state_q     <= StFail;
          fail_code_q <= dmem_din;
        end
      end else if (wd_expire) begin
        state_q <= StTimeout;
      end
    end
  end

  // Full implies non-empty, so a ready consumer always frees a slot this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (console_hit && fifo_full && !console_ready) begin
      overflow_q <= 1'b1;
    end
  end

  rv_mmio_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (console_hit),
    .push_data(dmem_din[7:0]),
    .pop      (console_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (console_data)
  );

  assign done_flag        = (state_q == StPass) || (state_q == StFail);
  assign pass_flag        = (state_q == StPass);
  assign fail_flag        = (state_q == StFail);
  assign timeout_flag     = (state_q == StTimeout);
  assign fail_code        = fail_code_q;
  assign cycle_count      = cycle_q;
  assign store_count      = store_q;
  assign console_valid    = !fifo_empty;
  assign console_overflow = overflow_q;

endmodule

// File: tb/tb_rv_mmio_monitor.sv
// Bench for rv_mmio_monitor: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rv_mmio_monitor;

  localparam logic [31:0] DONE = 32'h0000_2000;
  localparam logic [31:0] CON  = 32'h0000_2004;
  localparam logic [31:0] PASSV = 32'hDEAD_BEEF;
  localparam int TMO = 50;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, din;
  logic        we, ready;
  logic        done_flag, pass_flag, fail_flag, timeout_flag, console_valid, console_overflow;
  logic [31:0] fail_code, cycle_count, store_count;
  logic [7:0]  console_data;

  int total = 0;
  int bad = 0;
  bit cmp_en = 0;

  // Reference model state
  bit          m_pass, m_fail, m_to, m_ovf;
  logic [31:0] m_code, m_cyc, m_st;
  logic [7:0]  m_q[$];
  logic [7:0]  m_head;

  rv_mmio_monitor #(
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .dmem_addr       (addr),
    .dmem_we         (we),
    .dmem_din        (din),
    .done_flag       (done_flag),
    .pass_flag       (pass_flag),
    .fail_flag       (fail_flag),
    .fail_code       (fail_code),
    .timeout_flag    (timeout_flag),
    .cycle_count     (cycle_count),
    .store_count     (store_count),
    .console_valid   (console_valid),
    .console_data    (console_data),
    .console_ready   (ready),
    .console_overflow(console_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    logic [31:0] old_cyc;
    if (rst) begin
      m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0;
      m_code = 0; m_cyc = 0; m_st = 0; m_head = 0;
      m_q.delete();
    end else begin
      if (!(m_pass || m_fail || m_to)) begin
        old_cyc = m_cyc;
        if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (we && m_st != 32'hFFFF_FFFF) m_st = m_st + 1;
        if (we && addr == DONE) begin
          if (din == PASSV) m_pass = 1;
          else begin
            m_fail = 1;
            m_code = din;
          end
        end else if (old_cyc == TMO - 1) begin
          m_to = 1;
        end
      end
      if (ready && m_q.size() > 0) void'(m_q.pop_front());
      if (we && addr == CON) begin
        if (m_q.size() < DEPTH) m_q.push_back(din[7:0]);
        else m_ovf = 1;
      end
      if (m_q.size() > 0) m_head = m_q[0];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("done_flag", {31'b0, done_flag}, {31'b0, m_pass | m_fail});
      check("pass_flag", {31'b0, pass_flag}, {31'b0, m_pass});
      check("fail_flag", {31'b0, fail_flag}, {31'b0, m_fail});
      check("timeout_flag", {31'b0, timeout_flag}, {31'b0, m_to});
      check("fail_code", fail_code, m_code);
      check("cycle_count", cycle_count, m_cyc);
      check("store_count", store_count, m_st);
      check("console_valid", {31'b0, console_valid}, {31'b0, m_q.size() > 0});
      check("console_overflow", {31'b0, console_overflow}, {31'b0, m_ovf});
      if (m_q.size() > 0) check("console_data", {24'b0, console_data}, {24'b0, m_head});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a; din = d; we = 1;
    @(negedge clk);
    we = 0;
  endtask

  task automatic push(input logic [7:0] b, input logic r);
    addr = CON; din = {24'h0, b}; we = 1; ready = r;
    @(negedge clk);
    we = 0; ready = 0;
  endtask

  task automatic pulse();
    ready = 1;
    @(negedge clk);
    ready = 0;
  endtask

  initial begin
    rst = 1; we = 0; addr = 0; din = 0; ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    cmp_en = 1;

    // Reset values
    check("rst_done", {31'b0, done_flag}, 0);
    check("rst_timeout", {31'b0, timeout_flag}, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_valid", {31'b0, console_valid}, 0);
    check("rst_cdata", {24'b0, console_data}, 0);
    check("rst_code", fail_code, 0);

    // PASS at cycle 10, later store ignored
    do_reset();
    idle(10);
    store(DONE, PASSV);
    check("pass_pass", {31'b0, pass_flag}, 1);
    check("pass_done", {31'b0, done_flag}, 1);
    check("pass_fail", {31'b0, fail_flag}, 0);
    check("pass_cycles", cycle_count, 11);
    store(DONE, 32'h1);
    idle(3);
    check("pass_hold", {31'b0, pass_flag}, 1);
    check("pass_nofail", {31'b0, fail_flag}, 0);
    check("pass_code", fail_code, 0);
    check("pass_frozen", cycle_count, 11);
    check("pass_stores", store_count, 1);

    // FAIL
    do_reset();
    idle(3);
    store(DONE, 32'h7);
    check("fail_fail", {31'b0, fail_flag}, 1);
    check("fail_done", {31'b0, done_flag}, 1);
    check("fail_pass", {31'b0, pass_flag}, 0);
    check("fail_code", fail_code, 7);

    // Watchdog
    do_reset();
    idle(TMO - 1);
    check("to_before", {31'b0, timeout_flag}, 0);
    idle(1);
    check("to_flag", {31'b0, timeout_flag}, 1);
    check("to_cycles", cycle_count, TMO);
    idle(5);
    check("to_frozen", cycle_count, TMO);

    // Termination store on the last watchdog cycle wins
    do_reset();
    idle(TMO - 1);
    store(DONE, PASSV);
    check("race_pass", {31'b0, pass_flag}, 1);
    check("race_to", {31'b0, timeout_flag}, 0);
    idle(3);
    check("race_to_late", {31'b0, timeout_flag}, 0);

    // Console ordering
    do_reset();
    push(8'h48, 0);
    check("con_valid", {31'b0, console_valid}, 1);
    check("con_first", {24'b0, console_data}, 32'h48);
    push(8'h69, 0);
    pulse();
    check("con_second", {24'b0, console_data}, 32'h69);
    pulse();
    check("con_empty", {31'b0, console_valid}, 0);

    // Overflow with depth 4
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 0);
    check("ovf_none", {31'b0, console_overflow}, 0);
    push(8'h20, 1);
    check("ovf_pushpop", {31'b0, console_overflow}, 0);
    check("ovf_head", {24'b0, console_data}, 32'h11);
    push(8'h21, 0);
    check("ovf_set", {31'b0, console_overflow}, 1);
    check("ovf_head2", {24'b0, console_data}, 32'h11);
    ready = 1;
    idle(6);
    ready = 0;
    check("ovf_drained", {31'b0, console_valid}, 0);

    // Reset after FAIL with queued bytes; store during reset is not observed
    do_reset();
    push(8'h41, 0);
    push(8'h42, 0);
    push(8'h43, 0);
    store(DONE, 32'h9);
    check("rf_fail", {31'b0, fail_flag}, 1);
    rst = 1; addr = DONE; din = PASSV; we = 1;
    @(negedge clk);
    rst = 0; we = 0;
    check("rf_fail0", {31'b0, fail_flag}, 0);
    check("rf_done0", {31'b0, done_flag}, 0);
    check("rf_pass0", {31'b0, pass_flag}, 0);
    check("rf_code0", fail_code, 0);
    check("rf_cyc0", cycle_count, 0);
    check("rf_st0", store_count, 0);
    check("rf_valid0", {31'b0, console_valid}, 0);
    idle(2);
    check("rf_nopass", {31'b0, pass_flag}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_mmio_monitor.md
# rv_mmio_monitor

Parametrised memory-mapped test monitor that snoops the pipelined core's data-memory write port and replaces the single fixed-address done flag with a full end-of-test unit. It decodes a configurable termination address into pass/fail/timeout outcomes, counts cycles and stores, and buffers character writes to a console address in a FIFO for the bench or a UART to drain. It sits beside the core in the processor wrapper, purely as an observer of `dmem_addr`/`dmem_we`/`dmem_din`. It never stalls or alters the memory bus.

## Interface
- `ADDR_W`, 32, snooped address width
- `DATA_W`, 32, snooped data width (≥ 8)
- `DONE_ADDR`, 32'h0000_2000, termination register address
- `PASS_VALUE`, 32'hDEADBEEF, value at `DONE_ADDR` meaning pass; any other value means fail
- `CONSOLE_ADDR`, 32'h0000_2004, console character register address
- `FIFO_DEPTH`, 16, console FIFO entries (power of two, ≥ 2)
- `CNT_W`, 32, cycle/store counter width
- `TIMEOUT_CYCLES`, 1_000_000, RUN cycles before timeout; 0 disables the watchdog
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `dmem_addr` in ADDR_W: snooped store address
- `dmem_we` in 1: snooped store enable
- `dmem_din` in DATA_W: snooped store data
- `done_flag` out 1: program terminated (pass or fail), sticky
- `pass_flag` out 1: terminated with `PASS_VALUE`, sticky
- `fail_flag` out 1: terminated with any other value, sticky
- `fail_code` out DATA_W: value written on fail; 0 otherwise
- `timeout_flag` out 1: watchdog expired, sticky
- `cycle_count` out CNT_W: cycles spent in RUN
- `store_count` out CNT_W: `dmem_we` cycles seen in RUN
- `console_valid` out 1: FIFO non-empty
- `console_data` out 8: FIFO head byte
- `console_ready` in 1: consumer pops head when `console_valid && console_ready`
- `console_overflow` out 1: a console write was dropped, sticky

## Operation
- State machine: RUN → PASS | FAIL | TIMEOUT. The terminal states are absorbing until `rst`.
- RUN, on `dmem_we && dmem_addr==DONE_ADDR`:
  - If `dmem_din==PASS_VALUE`: go to PASS.
  - Otherwise: go to FAIL and latch `fail_code <= dmem_din`.
- RUN, watchdog: if `TIMEOUT_CYCLES != 0` and `cycle_count == TIMEOUT_CYCLES-1` with no termination store that cycle, go to TIMEOUT. A termination store in the same cycle wins over timeout.
- Flags are decoded from the state register:
  - `done_flag` = PASS|FAIL.
  - `pass_flag` = PASS.
  - `fail_flag` = FAIL.
  - `timeout_flag` = TIMEOUT.
- `cycle_count` increments each RUN cycle and freezes on leaving RUN. It saturates at all-ones.
- `store_count` increments on each `dmem_we` cycle while in RUN. The terminating store is counted. It saturates.
- Stores to DONE_ADDR after termination are ignored; `fail_code` does not change.
- Console: `dmem_we && dmem_addr==CONSOLE_ADDR` pushes `dmem_din[7:0]`. This is accepted in every state, so output can drain after termination.
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `console_overflow` is set.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - Popping when empty is ignored.
- Address compares use the full `ADDR_W` and exact match. Other addresses are ignored.

## Timing
- All outputs are registered. The flags and `fail_code` update on the edge that samples the terminating store, so they are visible the next cycle.
- The console FIFO has 1-cycle latency and no bypass: a byte pushed at edge N gives `console_valid` after edge N. `console_data` is valid whenever `console_valid` is high and holds until popped.
- Reset values:
  - State: RUN.
  - All flags: 0.
  - `fail_code`: 0.
  - Counters: 0.
  - FIFO: empty, so `console_valid` = 0.
  - `console_data`: 0.
  - `console_overflow`: 0.
- Reset mid-run or after termination returns to RUN with everything cleared in the same edge, and discards FIFO contents.
- The store on the cycle `rst` is high is not observed.

## Structure
- Package `rv_mmio_pkg` holds:
  - The state enum (RUN, PASS, FAIL, TIMEOUT).
  - Default `DONE_ADDR`, `CONSOLE_ADDR` and `PASS_VALUE` constants, shared with the software test harness.
- Sub-module `rv_mmio_fifo` is a synchronous FIFO with parameters WIDTH and DEPTH. It provides push/pop, full/empty and a head register, and uses pointers one bit wider than log2(DEPTH) for full/empty detection.
- The top level holds the decode, the FSM, the counters and the overflow flag.

## Test plan
- PASS: store 32'hDEADBEEF to 0x2000 at cycle 10.
  - Next cycle: `done_flag`=`pass_flag`=1, `fail_flag`=0.
  - `cycle_count` frozen at 11; a later store to 0x2000 of 0x1 changes nothing.
- FAIL: store 0x0000_0007 to 0x2000.
  - `done_flag`=`fail_flag`=1, `fail_code`=7, `pass_flag`=0.
- Timeout: with `TIMEOUT_CYCLES`=50, run with no stores.
  - `timeout_flag` rises after cycle 50, `cycle_count`=50.
  - A PASS store on exactly cycle 49 yields PASS, not timeout.
- Console: write bytes 0x48, 0x69 to 0x2004 with `console_ready`=0.
  - `console_valid` goes high one cycle later with `console_data`=0x48.
  - After a ready pulse, head is 0x69; after a second pulse, `console_valid`=0.
- Overflow: with `FIFO_DEPTH`=4, push 5 bytes with ready=0.
  - 4 bytes are held and `console_overflow`=1.
  - Push concurrent with pop while full is accepted, with no overflow.
- Reset: assert `rst` for one cycle after FAIL with 3 bytes queued.
  - All flags, counters and `fail_code` read 0, and `console_valid`=0.
